loopbuf_ctrl: RTL and testbench

LOOPBUF_CTRL -- requirements
Module: loopbuf_ctrl

---
 rtl/loopbuf_pkg.sv | 15 +
 rtl/sync_rise.sv | 28 ++
 rtl/loopbuf_ctrl.sv | 147 ++++++++++++++
 tb/tb_loopbuf_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loopbuf_pkg.sv
// Shared types and defaults for the RS-232 loop-buffer fill/drain controller.
package loopbuf_pkg;

   localparam int FILL_BITS_DEF = 10000;
   localparam int CNT_W_DEF     = 14;
   localparam int BYTE_W        = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
module sync_rise (
   input  logic rcvbuf_clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge rcvbuf_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/loopbuf_ctrl.sv
// Fills an external flop chain LSB-first from received bytes, then drains it with zeros.
// Define LOOPBUF_OVERRUN_EN to add a sticky overrun output for bytes arriving while busy.
module loopbuf_ctrl
   import loopbuf_pkg::*;
#(
   parameter int FILL_BITS = FILL_BITS_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic              rcvbuf_clk,
   input  logic              rst,
   input  logic              tick_1200,
   input  logic              newdata,
   input  logic [BYTE_W-1:0] rbr,
   output logic              chain_en,
   output logic              feed,
   output logic              ack,
   output logic              rfd,
   output logic              rx_full,
   output logic              rx_empty,
   output logic              start
`ifdef LOOPBUF_OVERRUN_EN
   ,
   output logic              overrun
`endif
);

   localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(FILL_BITS);
   localparam logic [CNT_W-1:0] FILL_ONE = CNT_W'(1);
   localparam logic [2:0]       LAST_BIT = 3'(BYTE_W - 1);

   state_e              state_q,    state_d;
   logic [BYTE_W-1:0]   shreg_q,    shreg_d;
   logic [2:0]          bit_cnt_q,  bit_cnt_d;
   logic [CNT_W-1:0]    fill_q,     fill_d;
   logic                ack_q,      ack_d;
   logic                rx_empty_q, rx_empty_d;
   logic                rise;

   sync_rise u_sync_rise (
      .rcvbuf_clk (rcvbuf_clk),
      .rst        (rst),
      .async_in   (newdata),
      .rise       (rise)
   );

   always_comb begin
      // NOTE: every next-state and output gets a default first, so no branch can infer a latch.
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      fill_d     = fill_q;
      ack_d      = 1'b0;
      rx_empty_d = 1'b0;
      chain_en   = 1'b0;
      feed       = 1'b0;
      rfd        = 1'b0;
      rx_full    = 1'b0;
      start      = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A tick in the same cycle as the capture is deliberately not a shift.
            rfd = 1'b1;
            if (rise) begin
               shreg_d   = rbr;
               bit_cnt_d = '0;
               ack_d     = 1'b1;
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            if (tick_1200) begin
               chain_en = 1'b1;
               feed     = shreg_q[0];
               shreg_d  = {1'b0, shreg_q[BYTE_W-1:1]};
               if (fill_q != FILL_MAX) begin
                  fill_d = fill_q + FILL_ONE;
               end
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = (fill_d == FILL_MAX) ? FULL : IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end

         FULL: begin
            rx_full = 1'b1;
            state_d = DRAIN;
         end

         DRAIN: begin
            start = 1'b1;
            if (tick_1200) begin
               chain_en = 1'b1;
               if (fill_q != '0) begin
                  fill_d = fill_q - FILL_ONE;
               end
            end
            if (fill_d == '0) begin
               state_d    = IDLE;
               rx_empty_d = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge rcvbuf_clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         fill_q     <= '0;
         ack_q      <= 1'b0;
         rx_empty_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         fill_q     <= fill_d;
         ack_q      <= ack_d;
         rx_empty_q <= rx_empty_d;
      end
   end

   assign ack      = ack_q;
   assign rx_empty = rx_empty_q;

`ifdef LOOPBUF_OVERRUN_EN
   logic overrun_q;

   always_ff @(posedge rcvbuf_clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if (rise && (state_q != IDLE)) begin
         overrun_q <= 1'b1;
      end
   end

   assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_loopbuf_ctrl.sv
// Randomized scoreboard bench for loopbuf_ctrl: a small-chain instance and a default-size instance.
module tb_loopbuf_ctrl;

   localparam int FB = 16;

   typedef enum int {EV_ACK, EV_BIT, EV_FULL, EV_EMPTY} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      logic     feed;
      logic     start;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst, tick, newdata;
   logic [7:0] rbr;
   logic       chain_en, feed, ack, rfd, rx_full, rx_empty, start;
   logic       tick2, newdata2;
   logic [7:0] rbr2;
   logic       chain_en2, feed2, ack2, rfd2, rx_full2, rx_empty2, start2;
`ifdef LOOPBUF_OVERRUN_EN
   logic       overrun, overrun2;
`endif

   always #5 clk = ~clk;

   loopbuf_ctrl #(.FILL_BITS(FB), .CNT_W(6)) u_dut (
      .rcvbuf_clk (clk),
      .rst        (rst),
      .tick_1200  (tick),
      .newdata    (newdata),
      .rbr        (rbr),
      .chain_en   (chain_en),
      .feed       (feed),
      .ack        (ack),
      .rfd        (rfd),
      .rx_full    (rx_full),
      .rx_empty   (rx_empty),
      .start      (start)
`ifdef LOOPBUF_OVERRUN_EN
      ,
      .overrun    (overrun)
`endif
   );

   loopbuf_ctrl u_big (
      .rcvbuf_clk (clk),
      .rst        (rst),
      .tick_1200  (tick2),
      .newdata    (newdata2),
      .rbr        (rbr2),
      .chain_en   (chain_en2),
      .feed       (feed2),
      .ack        (ack2),
      .rfd        (rfd2),
      .rx_full    (rx_full2),
      .rx_empty   (rx_empty2),
      .start      (start2)
`ifdef LOOPBUF_OVERRUN_EN
      ,
      .overrun    (overrun2)
`endif
   );

   int  n_checks = 0;
   int  n_err    = 0;
   ev_t exp_q[$];
   int  fill_m   = 0;
   bit  ov_m     = 1'b0;
   bit  mon_en   = 1'b0;

   // default-size instance observations
   int  big_fill_ticks = 0, big_fill_ones = 0, big_full_cnt = 0, big_full_at = -1;
   int  big_drain_ticks = 0, big_drain_ones = 0, big_empty_cnt = 0, big_drain_at = -1;
   int  big_acks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic consume(input ev_kind_e k, input logic f, input logic s);
      ev_t e;
      if (exp_q.size() == 0) begin
         check({"spurious_", k.name()}, exp_q.size(), 1);
         return;
      end
      e = exp_q.pop_front();
      check({"event_kind_", k.name()}, k, e.kind);
      if (k == EV_BIT && e.kind == EV_BIT) begin
         check("feed_bit", f, e.feed);
         check("start_during_bit", s, e.start);
      end
   endtask

   // scoreboard monitor for the small instance
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (ack === 1'b1) consume(EV_ACK, 1'b0, 1'b0);
            if (chain_en === 1'b1) consume(EV_BIT, feed, start);
            else check("feed_without_enable", feed, 1'b0);
            if (rx_full === 1'b1) begin
               consume(EV_FULL, 1'b0, 1'b0);
               check("rfd_while_full", rfd, 1'b0);
            end
            if (rx_empty === 1'b1) begin
               consume(EV_EMPTY, 1'b0, 1'b0);
               check("rfd_after_drain", rfd, 1'b1);
               check("start_after_drain", start, 1'b0);
            end
         end
      end
   end

   // tallies for the default-size instance
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (ack2 === 1'b1) big_acks++;
            if (chain_en2 === 1'b1 && start2 !== 1'b1) begin
               big_fill_ticks++;
               if (feed2 === 1'b1) big_fill_ones++;
            end
            if (chain_en2 === 1'b1 && start2 === 1'b1) begin
               big_drain_ticks++;
               if (feed2 !== 1'b0) big_drain_ones++;
            end
            if (rx_full2 === 1'b1) begin
               big_full_cnt++;
               big_full_at = big_fill_ticks;
            end
            if (rx_empty2 === 1'b1) begin
               big_empty_cnt++;
               big_drain_at = big_drain_ticks;
            end
         end
      end
   end

   task automatic push_byte_model(input logic [7:0] b);
      exp_q.push_back('{EV_ACK, 1'b0, 1'b0});
      for (int i = 0; i < 8; i++) exp_q.push_back('{EV_BIT, b[i], 1'b0});
      fill_m += 8;
      if (fill_m == FB) begin
         exp_q.push_back('{EV_FULL, 1'b0, 1'b0});
         for (int i = 0; i < FB; i++) exp_q.push_back('{EV_BIT, 1'b0, 1'b1});
         exp_q.push_back('{EV_EMPTY, 1'b0, 1'b0});
         fill_m = 0;
      end
   endtask

   // second rise while busy: rbr changes, but the byte already captured must still come out
   task automatic busy_rise(input logic [7:0] junk);
      tick    = 1'b0;
      rbr     = junk;
      newdata = 1'b1;
      repeat (5) cyc();
      newdata = 1'b0;
      repeat (3) cyc();
      ov_m = 1'b1;
   endtask

   // Called at a posedge+1 point; returns at a posedge+1 point.
   task automatic send_byte(input logic [7:0] b, input bit coinc, input bit extra, input bit abort);
      int ticks  = 0;
      int budget = 0;
      bit pend   = extra;
      push_byte_model(b);
      rbr     = b;
      newdata = 1'b1;
      tick    = 1'b0;
      cyc();
      cyc();
      tick = coinc;
      @(negedge clk);
      check("ack_early", ack, 1'b0);
      cyc();
      tick = 1'b0;
      @(negedge clk);
      check("ack_latency", ack, 1'b1);
      cyc();
      newdata = 1'b0;
      while (exp_q.size() != 0 && budget < 400) begin
         if (pend && ticks == 3) begin
            busy_rise(~b);
            pend = 1'b0;
         end
         if (abort && exp_q.size() == 6) begin
            // drain has 5 bits left: the fill count is 5
            tick = 1'b0;
            rst  = 1'b1;
            cyc();
            rst = 1'b0;
            exp_q.delete();
            fill_m = 0;
            ov_m   = 1'b0;
            @(negedge clk);
            check("reset_in_drain_outputs",
                  {rfd, ack, chain_en, feed, rx_full, rx_empty, start}, 7'b1000000);
            repeat (4) cyc();
            break;
         end
         tick = ($urandom_range(0, 2) != 0);
         if (tick && ticks < 8) ticks++;
         cyc();
         budget++;
      end
      tick = 1'b0;
      check("events_outstanding", exp_q.size(), 0);
      exp_q.delete();
`ifdef LOOPBUF_OVERRUN_EN
      check("overrun", overrun, ov_m);
`endif
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int         ones_exp;
      int         budget;

      rst      = 1'b1;
      tick     = 1'b0;
      newdata  = 1'b0;
      rbr      = 8'h00;
      tick2    = 1'b0;
      newdata2 = 1'b0;
      rbr2     = 8'h00;
      repeat (3) cyc();
      @(negedge clk);
      check("reset_outputs", {rfd, ack, chain_en, feed, rx_full, rx_empty, start}, 7'b1000000);
      check("reset_outputs_big", {rfd2, ack2, chain_en2, feed2, rx_full2, rx_empty2, start2},
            7'b1000000);
`ifdef LOOPBUF_OVERRUN_EN
      check("reset_overrun", overrun, 1'b0);
`endif
      cyc();
      rst    = 1'b0;
      mon_en = 1'b1;
      cyc();

      send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
      send_byte(8'h3C, 1'b0, 1'b1, 1'b0);
      send_byte(8'h01, 1'b0, 1'b0, 1'b0);
      send_byte(8'h80, 1'b0, 1'b0, 1'b0);
      send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
      send_byte(8'hC3, 1'b1, 1'b0, 1'b0);
      send_byte(8'h96, 1'b0, 1'b0, 1'b0);
      send_byte(8'h69, 1'b0, 1'b0, 1'b1);
      for (int n = 0; n < 24; n++) begin
         b = 8'($urandom);
         send_byte(b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0);
      end

      // default-size chain: 1250 bytes fill it exactly, then a full drain
      ones_exp = 0;
      for (int n = 0; n < 1250; n++) begin
         b        = 8'($urandom);
         ones_exp += $countones(b);
         rbr2     = b;
         newdata2 = 1'b1;
         repeat (3) cyc();
         newdata2 = 1'b0;
         tick2    = 1'b1;
         repeat (8) cyc();
         tick2 = 1'b0;
      end
      check("big_full_not_before_drain", big_drain_ticks, 0);
      tick2  = 1'b1;
      budget = 0;
      while (big_empty_cnt == 0 && budget < 10100) begin
         cyc();
         budget++;
      end
      tick2 = 1'b0;
      cyc();
      @(negedge clk);
      check("big_ack_count", big_acks, 1250);
      check("big_full_count", big_full_cnt, 1);
      check("big_full_after_tick", big_full_at, 10000);
      check("big_fill_ones", big_fill_ones, ones_exp);
      check("big_empty_count", big_empty_cnt, 1);
      check("big_drain_ticks", big_drain_at, 10000);
      check("big_drain_feed_ones", big_drain_ones, 0);
      check("big_rfd_after_drain", rfd2, 1'b1);
`ifdef LOOPBUF_OVERRUN_EN
      check("big_overrun", overrun2, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
